// File: rtl/ofm_writeback_packer_if.sv
// OFM writeback bus: the conv-core capture side (valid/ofm_in) and the
// BRAM write side (ofm_we/ofm_addr/ofm_wdata) of the writeback packer.
interface ofm_writeback_packer_if #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 20
);
    logic [NUM_PE-1:0]   valid;
    logic [8*NUM_PE-1:0] ofm_in;
    logic                ofm_we;
    logic [ADDR_W-1:0]   ofm_addr;
    logic [31:0]         ofm_wdata;

    modport master (
        output valid,
        output ofm_in,
        input  ofm_we,
        input  ofm_addr,
        input  ofm_wdata
    );

    modport slave (
        input  valid,
        input  ofm_in,
        output ofm_we,
        output ofm_addr,
        output ofm_wdata
    );
endinterface

// File: rtl/ofm_writeback_packer.sv
// OFM writeback packer: captures full 16-PE output pixels, buffers them in a
// small FIFO and bursts each one to the OFM BRAM as four 32-bit HWC words.
module ofm_writeback_packer #(
    parameter int NUM_PE     = 16,
    parameter int OFM_PIXELS = 3136,
    parameter int OFM_CH     = 32,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    ofm_writeback_packer_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err_partial
);
    localparam int TILES  = OFM_CH / NUM_PE;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PIX_W  = (OFM_PIXELS > 1) ? $clog2(OFM_PIXELS) : 1;
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [NUM_PE-1:0] VALID_ALL   = {NUM_PE{1'b1}};
    localparam logic [NUM_PE-1:0] VALID_NONE  = {NUM_PE{1'b0}};
    localparam logic [ADDR_W-1:0] PIX_STRIDE  = ADDR_W'(OFM_CH / 4);
    localparam logic [ADDR_W-1:0] TILE_STRIDE = ADDR_W'(NUM_PE / 4);
    localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(OFM_PIXELS - 1);
    localparam logic [TILE_W-1:0] TILE_LAST   = TILE_W'(TILES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    // Word k carries PE4k..PE4k+3, lowest PE in the most significant byte.
    function automatic logic [31:0] pack_word(input logic [8*NUM_PE-1:0] data,
                                              input logic [1:0] k);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = data[8*(4*int'(k)+j) +: 8];
        end
        return w;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [1:0]          state_r;
    logic [8*NUM_PE-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                active_r;
    logic [1:0]          k_r;
    logic [8*NUM_PE-1:0] burst_r;
    logic [ADDR_W-1:0]   burst_addr_r;
    logic [PIX_W-1:0]    pix_r;
    logic [TILE_W-1:0]   tile_r;
    logic [ADDR_W-1:0]   pix_base_r, tile_off_r;
    logic                fin_pend_r;
    logic                ofm_we_r;
    logic [ADDR_W-1:0]   ofm_addr_r;
    logic [31:0]         ofm_wdata_r;
    logic                done_r, overflow_r, err_partial_r;

    logic capture_en_s, push_req_s, partial_s, pop_s, full_s, push_s, drop_s;

    // Capture qualification, FIFO push/pop decisions and flag events.
    always_comb begin
        capture_en_s = (state_r == ST_RUN) && !start && !fin_pend_r;
        push_req_s   = capture_en_s && (bus.valid == VALID_ALL);
        partial_s    = capture_en_s && (bus.valid != VALID_ALL) && (bus.valid != VALID_NONE);
        full_s       = (count_r == CNT_FULL);
        pop_s        = (state_r == ST_RUN) && !start && !fin_pend_r && !active_r &&
                       (count_r != {CNT_W{1'b0}});
        push_s       = push_req_s && (!full_s || pop_s);
        drop_s       = push_req_s && full_s && !pop_s;
    end

    // FSM, FIFO, burst engine, pixel/tile walk and registered BRAM outputs.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            state_r       <= reset ? ST_IDLE : ST_RUN;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(8*NUM_PE){1'b0}};
            end
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            active_r      <= 1'b0;
            k_r           <= 2'd0;
            burst_r       <= {(8*NUM_PE){1'b0}};
            burst_addr_r  <= {ADDR_W{1'b0}};
            pix_r         <= {PIX_W{1'b0}};
            tile_r        <= {TILE_W{1'b0}};
            pix_base_r    <= {ADDR_W{1'b0}};
            tile_off_r    <= {ADDR_W{1'b0}};
            fin_pend_r    <= 1'b0;
            ofm_we_r      <= 1'b0;
            done_r        <= 1'b0;
            overflow_r    <= 1'b0;
            err_partial_r <= 1'b0;
            if (reset) begin
                ofm_addr_r  <= {ADDR_W{1'b0}};
                ofm_wdata_r <= 32'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.ofm_in;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (partial_s) begin
                err_partial_r <= 1'b1;
            end

            if (pop_s) begin
                // Word 0 leaves straight from the FIFO head; the rest from burst_r.
                burst_r      <= mem_r[rd_ptr_r];
                burst_addr_r <= pix_base_r + tile_off_r;
                active_r     <= 1'b1;
                k_r          <= 2'd1;
                ofm_we_r     <= 1'b1;
                ofm_addr_r   <= pix_base_r + tile_off_r;
                ofm_wdata_r  <= pack_word(mem_r[rd_ptr_r], 2'd0);
            end else if (active_r) begin
                ofm_we_r    <= 1'b1;
                ofm_addr_r  <= burst_addr_r + ADDR_W'(k_r);
                ofm_wdata_r <= pack_word(burst_r, k_r);
                k_r         <= k_r + 2'd1;
                if (k_r == 2'd3) begin
                    active_r <= 1'b0;
                    if (pix_r == PIX_LAST) begin
                        pix_r      <= {PIX_W{1'b0}};
                        pix_base_r <= {ADDR_W{1'b0}};
                        if (tile_r == TILE_LAST) begin
                            tile_r     <= {TILE_W{1'b0}};
                            tile_off_r <= {ADDR_W{1'b0}};
                            fin_pend_r <= 1'b1;
                        end else begin
                            tile_r     <= tile_r + TILE_W'(1);
                            tile_off_r <= tile_off_r + TILE_STRIDE;
                        end
                    end else begin
                        pix_r      <= pix_r + PIX_W'(1);
                        pix_base_r <= pix_base_r + PIX_STRIDE;
                    end
                end
            end else begin
                ofm_we_r <= 1'b0;
            end

            // Final word went out last cycle: raise done and drop anything late.
            if (fin_pend_r) begin
                fin_pend_r <= 1'b0;
                done_r     <= 1'b1;
                state_r    <= ST_DONE;
                wr_ptr_r   <= {PTR_W{1'b0}};
                rd_ptr_r   <= {PTR_W{1'b0}};
                count_r    <= {CNT_W{1'b0}};
            end
        end
    end

    assign bus.ofm_we    = ofm_we_r;
    assign bus.ofm_addr  = ofm_addr_r;
    assign bus.ofm_wdata = ofm_wdata_r;
    assign busy          = (state_r == ST_RUN) || (count_r != {CNT_W{1'b0}}) || active_r;
    assign done          = done_r;
    assign overflow      = overflow_r;
    assign err_partial   = err_partial_r;
endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Scoreboard bench for ofm_writeback_packer with a 4-pixel, 2-tile geometry.
module tb_ofm_writeback_packer;
    localparam int PIX = 4;
    localparam int CH  = 32;
    localparam int AW  = 20;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, overflow, err_partial;

    ofm_writeback_packer_if #(.NUM_PE(16), .ADDR_W(AW)) bus ();

    ofm_writeback_packer #(
        .NUM_PE(16), .OFM_PIXELS(PIX), .OFM_CH(CH), .ADDR_W(AW), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .overflow(overflow), .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  done_cyc = -1;
    int  total = 0;
    int  bad = 0;
    int  m_pix = 0;
    int  m_tile = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every BRAM write and the first cycle done is seen.
    always @(negedge clk) begin
        if (bus.ofm_we === 1'b1) obs_q.push_back('{cyc: 32'(cyc), addr: bus.ofm_addr, data: bus.ofm_wdata});
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic model_pixel(input logic [127:0] d);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            e.cyc  = 32'd0;
            e.addr = AW'(m_pix * (CH / 4) + m_tile * 4 + k);
            e.data = {d[8*(4*k)+:8], d[8*(4*k+1)+:8], d[8*(4*k+2)+:8], d[8*(4*k+3)+:8]};
            exp_q.push_back(e);
        end
        m_pix++;
        if (m_pix == PIX) begin
            m_pix = 0;
            m_tile++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_pix = 0; m_tile = 0; done_cyc = -1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic drive_pixel(input logic [127:0] d, input bit kept, output int c);
        bus.valid  = 16'hFFFF;
        bus.ofm_in = d;
        c = cyc;
        @(posedge clk); #1;
        bus.valid = 16'h0000;
        if (kept) model_pixel(d);
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && obs_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        ok = (obs_q.size() >= n);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.ofm_we, bus.ofm_addr, bus.ofm_wdata, busy, done, overflow, err_partial} !== 57'd0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b ovf=%b err=%b want all 0",
                     bus.ofm_we, bus.ofm_addr, bus.ofm_wdata, busy, done, overflow, err_partial);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [127:0] d;
        int  c;
        bit  ok;
        for (int i = 0; i < 16; i++) d[8*i+:8] = 8'(i);
        do_start();
        drive_pixel(d, 1'b1, c);
        wait_writes(4, 20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL single_timeout: got %0d writes want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_t o, e;
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total += 2;
                if (o.addr !== e.addr || o.data !== e.data) begin
                    bad++; $display("FAIL single_word%0d: got %h/%h want %h/%h", i, o.addr, o.data, e.addr, e.data);
                end
                if (int'(o.cyc) !== c + 2 + i) begin
                    bad++; $display("FAIL single_latency%0d: got cycle %0d want %0d", i, o.cyc, c + 2 + i);
                end
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.ofm_we !== 1'b0 || bus.ofm_addr !== 20'd3 || bus.ofm_wdata !== 32'h0C0D0E0F) begin
            bad++; $display("FAIL single_hold: got we=%b %h/%h want 0 00003/0c0d0e0f", bus.ofm_we, bus.ofm_addr, bus.ofm_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_second_pixel();
        int c;
        bit ok;
        drive_pixel(rnd128(), 1'b1, c);
        wait_writes(4, 20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL second_timeout: got %0d writes want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_t o, e;
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (o.addr !== e.addr || o.data !== e.data || o.addr !== AW'(8 + i)) begin
                    bad++; $display("FAIL second_word%0d: got %h/%h want %h/%h", i, o.addr, o.data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_partial();
        int c;
        bit ok;
        bus.valid  = 16'h00FF;
        bus.ofm_in = rnd128();
        @(posedge clk); #1;
        bus.valid = 16'h0000;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++;
        if (err_partial !== 1'b1 || obs_q.size() != 0) begin
            bad++; $display("FAIL partial_flag: got err=%b writes=%0d want err=1 writes=0", err_partial, obs_q.size());
        end
        @(posedge clk); #1;
        drive_pixel(rnd128(), 1'b1, c);
        wait_writes(4, 20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL partial_timeout: got %0d writes want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_t o, e;
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (o.addr !== e.addr || o.data !== e.data) begin
                    bad++; $display("FAIL partial_next%0d: got %h/%h want %h/%h", i, o.addr, o.data, e.addr, e.data);
                end
            end
        end
        do_start();
        @(negedge clk);
        total++;
        if (err_partial !== 1'b0) begin
            bad++; $display("FAIL partial_clear: got err=%b want 0", err_partial);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_overflow();
        int c, c0;
        bit ok;
        do_start();
        drive_pixel(rnd128(), 1'b1, c0);
        drive_pixel(rnd128(), 1'b1, c);
        drive_pixel(rnd128(), 1'b1, c);
        drive_pixel(rnd128(), 1'b0, c);
        wait_writes(12, 40, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL b2b_timeout: got %0d writes want 12", obs_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                wr_t o, e;
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (o.addr !== e.addr || o.data !== e.data || int'(o.cyc) !== c0 + 2 + i) begin
                    bad++; $display("FAIL b2b_word%0d: got %h/%h@%0d want %h/%h@%0d", i, o.addr, o.data, o.cyc, e.addr, e.data, c0 + 2 + i);
                end
            end
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (overflow !== 1'b1 || obs_q.size() != 0 || err_partial !== 1'b0) begin
            bad++; $display("FAIL b2b_overflow: got ovf=%b extra=%0d err=%b want ovf=1 extra=0 err=0", overflow, obs_q.size(), err_partial);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_run();
        int  c;
        bit  ok;
        int  last;
        int  seen[32];
        bit  cover_ok;
        do_start();
        for (int p = 0; p < 8; p++) begin
            drive_pixel(rnd128(), 1'b1, c);
            repeat (35) @(posedge clk);
            #1;
        end
        wait_writes(32, 100, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (!ok) begin
            bad++; $display("FAIL run_timeout: got %0d writes want 32", obs_q.size());
        end else begin
            foreach (seen[i]) seen[i] = 0;
            last = 0;
            for (int i = 0; i < 32; i++) begin
                wr_t o, e;
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o.addr < 32) seen[o.addr] = seen[o.addr] + 1;
                last = int'(o.cyc);
                total++;
                if (o.addr !== e.addr || o.data !== e.data) begin
                    bad++; $display("FAIL run_word%0d: got %h/%h want %h/%h", i, o.addr, o.data, e.addr, e.data);
                end
            end
            cover_ok = 1'b1;
            foreach (seen[i]) if (seen[i] != 1) cover_ok = 1'b0;
            total++;
            if (!cover_ok || obs_q.size() != 0) begin
                bad++; $display("FAIL run_coverage: got cover_ok=%b extra=%0d want 1/0", cover_ok, obs_q.size());
            end
            total++;
            if (done_cyc !== last + 1) begin
                bad++; $display("FAIL run_done_cycle: got %0d want %0d", done_cyc, last + 1);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL run_final: got done=%b busy=%b ovf=%b want 1/0/0", done, busy, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int c;
        do_start();
        drive_pixel(rnd128(), 1'b1, c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== 20'd1) begin
            bad++; $display("FAIL midrst_word1: got we=%b addr=%h want 1/00001", bus.ofm_we, bus.ofm_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.ofm_we, busy, done, overflow, err_partial} !== 5'd0) begin
            bad++; $display("FAIL midrst_outputs: got we=%b busy=%b done=%b ovf=%b err=%b want 0",
                            bus.ofm_we, busy, done, overflow, err_partial);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        obs_q.delete(); exp_q.delete();
        bus.valid  = 16'hFFFF;
        bus.ofm_in = rnd128();
        repeat (5) @(posedge clk);
        #1;
        bus.valid = 16'h0000;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_nostart: got writes=%0d busy=%b want 0/0", obs_q.size(), busy);
        end
    endtask

    initial begin
        bus.valid  = 16'h0000;
        bus.ofm_in = 128'd0;
        test_reset();
        test_single();
        test_second_pixel();
        test_partial();
        test_back_to_back_overflow();
        test_full_run();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
